// File: rtl/mvm_loader_pkg.sv
// Shared sizes and FSM encoding for the MVM host-side loader.
package mvm_loader_pkg;

    localparam int IWIDTH        = 8;
    localparam int MEM_DATAW     = IWIDTH * 8;
    localparam int VEC_MEM_DEPTH = 256;
    localparam int VEC_ADDRW     = $clog2(VEC_MEM_DEPTH);
    localparam int MAT_MEM_DEPTH = 512;
    localparam int MAT_ADDRW     = $clog2(MAT_MEM_DEPTH);
    localparam int NUM_OLANES    = 8;
    localparam int LANEW         = $clog2(NUM_OLANES);
    localparam int VEC_SIZEW     = VEC_ADDRW + 1;
    localparam int MAT_SIZEW     = MAT_ADDRW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        LOAD_MAT,
        LAUNCH,
        ACK
    } state_t;

endpackage

// File: rtl/mvm_loader_addr_gen.sv
// Word/lane/row counters and write-address generation for the loader.
// Matrix addresses use a running row base (mat_base + g*W) so no multiplier is needed.
module mvm_loader_addr_gen
    import mvm_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [VEC_ADDRW-1:0] vec_base,
    input  logic [MAT_ADDRW-1:0] mat_base,
    input  logic [VEC_SIZEW-1:0] num_words,
    input  logic [MAT_SIZEW-1:0] num_rows,
    input  logic                 vec_step,
    input  logic                 mat_step,
    output logic [VEC_ADDRW-1:0] vec_addr,
    output logic [MAT_ADDRW-1:0] mat_addr,
    output logic [LANEW-1:0]     lane,
    output logic                 last_vec,
    output logic                 last_mat
);

    logic [VEC_SIZEW-1:0] word;
    logic [MAT_SIZEW-1:0] row;
    logic [MAT_ADDRW-1:0] row_base;
    logic [VEC_ADDRW-1:0] vec_ptr;
    logic                 last_word;
    logic                 last_lane;

    assign last_word = (word == num_words - VEC_SIZEW'(1));
    assign last_lane = (lane == LANEW'(NUM_OLANES - 1));
    assign last_vec  = last_word;
    assign last_mat  = last_word && last_lane && (row == num_rows - MAT_SIZEW'(1));
    assign vec_addr  = vec_ptr;
    assign mat_addr  = row_base + MAT_ADDRW'(word);

    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= '0;
            lane     <= '0;
            row      <= '0;
            row_base <= '0;
            vec_ptr  <= '0;
        end else if (init) begin
            word     <= '0;
            lane     <= '0;
            row      <= '0;
            row_base <= mat_base;
            vec_ptr  <= vec_base;
        end else if (vec_step || mat_step) begin
            word <= last_word ? '0 : word + VEC_SIZEW'(1);
            if (vec_step)
                vec_ptr <= vec_ptr + VEC_ADDRW'(1);
            // Lane advances after each W-word sweep; row base steps by W after the last lane.
            if (mat_step && last_word) begin
                if (last_lane) begin
                    lane     <= '0;
                    row      <= row + MAT_SIZEW'(1);
                    row_base <= row_base + MAT_ADDRW'(num_words);
                end else begin
                    lane <= lane + LANEW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mvm_loader.sv
// Host-side writer for the MVM engine: vector load, lane-striped matrix load, start/ack.
// Optional MVM_LOADER_VEC_REUSE_EN adds cfg_vec_reuse to skip the vector load phase.
module mvm_loader
    import mvm_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [VEC_ADDRW-1:0]  cfg_vec_base,
    input  logic [VEC_SIZEW-1:0]  cfg_vec_num_words,
    input  logic [MAT_ADDRW-1:0]  cfg_mat_base,
    input  logic [MAT_SIZEW-1:0]  cfg_mat_rows,
`ifdef MVM_LOADER_VEC_REUSE_EN
    input  logic                  cfg_vec_reuse,
`endif
    input  logic [MEM_DATAW-1:0]  s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [MEM_DATAW-1:0]  vec_wdata,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic                  vec_wen,
    output logic [MEM_DATAW-1:0]  mat_wdata,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic                  start,
    output logic [VEC_ADDRW-1:0]  start_vec_addr,
    output logic [VEC_SIZEW-1:0]  start_vec_num,
    output logic [MAT_ADDRW-1:0]  start_mat_addr,
    output logic [MAT_SIZEW-1:0]  start_mat_rows,
    input  logic                  mvm_busy,
    output logic                  done
);

    state_t               state, state_nxt;
    logic                 cfg_fire, beat, job_empty, reuse;
    logic                 vec_step, mat_step, last_vec, last_mat;
    logic [VEC_ADDRW-1:0] gen_vec_addr;
    logic [MAT_ADDRW-1:0] gen_mat_addr;
    logic [LANEW-1:0]     gen_lane;
    logic [MEM_DATAW-1:0] wdata;

`ifdef MVM_LOADER_VEC_REUSE_EN
    assign reuse = cfg_vec_reuse;
`else
    assign reuse = 1'b0;
`endif

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign beat      = s_valid && s_ready;
    assign job_empty = (cfg_vec_num_words == '0) || (cfg_mat_rows == '0);
    assign vec_step  = beat && (state == LOAD_VEC);
    assign mat_step  = beat && (state == LOAD_MAT);
    assign vec_wdata = wdata;
    assign mat_wdata = wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        s_ready   = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !mvm_busy;
                if (cfg_valid && !mvm_busy && !job_empty)
                    state_nxt = reuse ? LOAD_MAT : LOAD_VEC;
            end
            LOAD_VEC: begin
                s_ready = 1'b1;
                if (s_valid && last_vec) state_nxt = LOAD_MAT;
            end
            LOAD_MAT: begin
                s_ready = 1'b1;
                if (s_valid && last_mat) state_nxt = LAUNCH;
            end
            LAUNCH:  state_nxt = ACK;
            ACK:     if (mvm_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata          <= '0;
            vec_waddr      <= '0;
            vec_wen        <= 1'b0;
            mat_waddr      <= '0;
            mat_wen        <= '0;
            start          <= 1'b0;
            done           <= 1'b0;
            start_vec_addr <= '0;
            start_vec_num  <= '0;
            start_mat_addr <= '0;
            start_mat_rows <= '0;
        end else begin
            vec_wen <= 1'b0;
            mat_wen <= '0;
            start   <= 1'b0;
            done    <= 1'b0;
            if (cfg_fire) begin
                start_vec_addr <= cfg_vec_base;
                start_vec_num  <= cfg_vec_num_words;
                start_mat_addr <= cfg_mat_base;
                start_mat_rows <= cfg_mat_rows;
                done           <= job_empty;
            end
            if (beat) wdata <= s_data;
            if (vec_step) begin
                vec_wen   <= 1'b1;
                vec_waddr <= gen_vec_addr;
            end
            if (mat_step) begin
                mat_wen   <= NUM_OLANES'(1) << gen_lane;
                mat_waddr <= gen_mat_addr;
            end
            // start lands one cycle after the last write is visible
            if (state == LAUNCH)          start <= 1'b1;
            if (state == ACK && mvm_busy) done  <= 1'b1;
        end
    end

    mvm_loader_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (cfg_fire),
        .vec_base  (cfg_vec_base),
        .mat_base  (cfg_mat_base),
        .num_words (start_vec_num),
        .num_rows  (start_mat_rows),
        .vec_step  (vec_step),
        .mat_step  (mat_step),
        .vec_addr  (gen_vec_addr),
        .mat_addr  (gen_mat_addr),
        .lane      (gen_lane),
        .last_vec  (last_vec),
        .last_mat  (last_mat)
    );

endmodule
